// File: rtl/pkg_25519.sv
// Shared constants and types for the GF(2^255-19) arithmetic blocks.
// The state enum is exported so the point-op sequencer can decode multiplier state for debug.
package pkg_25519;

  localparam logic [254:0] P_25519 =
    255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

  localparam int unsigned FOLD_K = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FOLD  = 2'd2,
    FINAL = 2'd3
  } state_e;

  // Only divisors of 255 (excluding 255 itself) give a whole number of digits.
  function automatic bit digit_w_ok(input int unsigned w);
    return (w == 1) || (w == 3) || (w == 5) || (w == 15) ||
           (w == 17) || (w == 51) || (w == 85);
  endfunction

endpackage

// File: rtl/fold_25519.sv
// Combinational pseudo-Mersenne fold: y = x[254:0] + 19*x[W-1:255], using 2^255 == 19 (mod p).
// Callers guarantee the folded value stays below 2^256.
module fold_25519
  import pkg_25519::*;
#(
  parameter int unsigned W = 256
) (
  input  logic [W-1:0] x,
  output logic [255:0] y
);

  logic [255:0] lo;
  logic [255:0] hi;

  assign lo = {1'b0, x[254:0]};
  assign hi = 256'(x[W-1:255]);
  assign y  = lo + (hi * 256'(FOLD_K));

endmodule

// File: rtl/mul_25519_ds.sv
// Digit-serial a*b mod (2^255-19), MSB-first Horner over DIGIT_W-bit digits of b.
// Fixed latency NUM_DIGITS+2 edges from start acceptance to done; start while busy is dropped.
module mul_25519_ds
  import pkg_25519::*;
#(
  parameter int unsigned DIGIT_W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic [254:0] res,
  output logic         done,
  output logic         busy
);

  localparam int unsigned NUM_DIGITS = 255 / DIGIT_W;
  localparam int unsigned TW         = 257 + DIGIT_W;
  localparam logic [7:0]  LAST_CNT   = 8'(NUM_DIGITS - 1);

  if (!digit_w_ok(DIGIT_W)) begin : g_bad_digit_w
    $error("mul_25519_ds: DIGIT_W must divide 255");
  end

  state_e       state_q;
  logic [254:0] a_q;
  logic [254:0] b_q;
  logic [255:0] acc_q;
  logic [7:0]   cnt_q;
  logic [254:0] res_q;
  logic         done_q;

  logic [DIGIT_W-1:0] digit;
  logic [TW-1:0]      iter_t;
  logic [255:0]       iter_acc_d;
  logic [255:0]       fold_acc_d;
  logic [255:0]       acc_minus_p;
  logic [254:0]       res_d;

  assign digit  = b_q[254 -: DIGIT_W];
  assign iter_t = (TW'(acc_q) << DIGIT_W) + (TW'(a_q) * TW'(digit));

  fold_25519 #(.W(TW)) u_iter_fold (
    .x (iter_t),
    .y (iter_acc_d)
  );

  fold_25519 #(.W(256)) u_final_fold (
    .x (acc_q),
    .y (fold_acc_d)
  );

  // After the last fold acc < p+38, so one conditional subtract fully reduces.
  assign acc_minus_p = acc_q - {1'b0, P_25519};
  assign res_d       = (acc_q >= {1'b0, P_25519}) ? acc_minus_p[254:0] : acc_q[254:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          acc_q <= iter_acc_d;
          b_q   <= b_q << DIGIT_W;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= FOLD;
          end
        end
        FOLD: begin
          acc_q   <= fold_acc_d;
          state_q <= FINAL;
        end
        FINAL: begin
          res_q   <= res_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res  = res_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mul_25519_ds.sv
// Bench for mul_25519_ds: three instances (DIGIT_W 15/17/5) against a bignum latency/result model.
module tb_mul_25519_ds;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start_v;
  logic [254:0] a;
  logic [254:0] b;
  logic [254:0] res_v [3];
  logic [2:0]   done_v;
  logic [2:0]   busy_v;

  mul_25519_ds #(.DIGIT_W(15)) u_d15 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b),
    .res(res_v[0]), .done(done_v[0]), .busy(busy_v[0])
  );
  mul_25519_ds #(.DIGIT_W(17)) u_d17 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b),
    .res(res_v[1]), .done(done_v[1]), .busy(busy_v[1])
  );
  mul_25519_ds #(.DIGIT_W(5)) u_d5 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b),
    .res(res_v[2]), .done(done_v[2]), .busy(busy_v[2])
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [254:0] pval();
    logic [255:0] t;
    t = (256'd1 << 255) - 256'd19;
    return t[254:0];
  endfunction

  function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] pr;
    logic [509:0] pp;
    logic [509:0] r;
    pp = {255'd0, pval()};
    pr = {255'd0, x} * {255'd0, y};
    r  = pr % pp;
    return r[254:0];
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 19;
      1:       return 17;
      default: return 53;
    endcase
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = (r << 32) | 256'($urandom());
    return r[254:0];
  endfunction

  task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: per instance, an accepted start yields mulmod(a,b) exactly lat_of(i) edges later.
  bit           m_busy [3];
  bit           m_done [3];
  int           m_left [3];
  logic [254:0] m_res  [3];
  logic [254:0] m_pend [3];
  bit           armed = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_left[i] = 0;
        m_res[i]  = '0;
      end else if (m_busy[i]) begin
        m_left[i] = m_left[i] - 1;
        m_done[i] = 1'b0;
        if (m_left[i] == 0) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
          m_res[i]  = m_pend[i];
        end
      end else begin
        m_done[i] = 1'b0;
        if (start_v[i]) begin
          m_busy[i] = 1'b1;
          m_left[i] = lat_of(i);
          m_pend[i] = mulmod(a, b);
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy[%0d]", i), 255'(busy_v[i]), 255'(m_busy[i]));
        chk($sformatf("done[%0d]", i), 255'(done_v[i]), 255'(m_done[i]));
        chk($sformatf("res[%0d]", i), res_v[i], m_res[i]);
      end
    end
  end

  // One operation on the DIGIT_W=15 instance, with literal latency and result checks.
  task automatic op15(input logic [254:0] xa, input logic [254:0] xb,
                      input logic [254:0] exp, input string nm);
    int busy_cnt;
    busy_cnt = 0;
    a = xa;
    b = xb;
    start_v[0] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) start_v[0] = 1'b0;
      if (k <= 18 && busy_v[0]) busy_cnt++;
      if (k == 19) begin
        chk({nm, " res"}, res_v[0], exp);
        chk({nm, " done@19"}, 255'(done_v[0]), 255'd1);
        chk({nm, " busy@19"}, 255'(busy_v[0]), 255'd0);
      end
      if (k == 20) chk({nm, " done@20"}, 255'(done_v[0]), 255'd0);
    end
    chk({nm, " busy cycles"}, 255'(busy_cnt), 255'd19);
  endtask

  initial begin
    logic [254:0] p;
    logic [254:0] x;
    int dones;
    p = pval();
    rst = 1'b1;
    start_v = '0;
    a = '0;
    b = '0;

    chk("model (p-1)^2", mulmod(p - 255'd1, p - 255'd1), 255'd1);
    chk("model 2^255-1", mulmod('1, 255'd1), 255'd18);

    repeat (3) @(posedge clk);
    #1;
    chk("reset res", res_v[0], '0);
    chk("reset busy", 255'(busy_v[0]), '0);
    chk("reset done", 255'(done_v[0]), '0);
    rst = 1'b0;

    op15(255'd2, 255'd3, 255'd6, "2*3");
    op15(p - 255'd1, p - 255'd1, 255'd1, "(p-1)^2");
    op15(255'd0, p - 255'd1, 255'd0, "0*(p-1)");
    x = '0;
    x[254] = 1'b1;
    op15(x, 255'd2, 255'd19, "2^254*2");
    op15('1, 255'd1, 255'd18, "(2^255-1)*1");

    // Start held for 25 edges: one op at edge 0, the next accepted at edge 20.
    a = 255'd3;
    b = 255'd4;
    start_v[0] = 1'b1;
    dones = 0;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        a = 255'd6;
        b = 255'd7;
      end
      if (k == 24) start_v[0] = 1'b0;
      if (done_v[0]) dones++;
      if (k == 19) begin
        chk("held done@19", 255'(done_v[0]), 255'd1);
        chk("held res1", res_v[0], 255'd12);
      end
      if (k == 39) begin
        chk("held done@39", 255'(done_v[0]), 255'd1);
        chk("held res2", res_v[0], 255'd42);
      end
    end
    chk("held done count", 255'(dones), 255'd2);

    // Reset in the middle of ITER: the aborted op must never report done.
    op15(255'd1000, 255'd1000, 255'd1000000, "1000^2");
    a = 255'd9;
    b = 255'd9;
    start_v[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) start_v[0] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", 255'(busy_v[0]), '0);
    chk("abort done", 255'(done_v[0]), '0);
    chk("abort res", res_v[0], '0);
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dones++;
    end
    chk("abort no done", 255'(dones), '0);
    op15(255'd5, 255'd7, 255'd35, "5*7");

    // Random operands on all three digit widths; results are checked by the model every cycle.
    for (int n = 0; n < 300; n++) begin
      a = rnd255();
      b = rnd255();
      if (n % 8 == 0) a = p + 255'($urandom_range(0, 18));
      if (n % 8 == 1) b = p + 255'($urandom_range(0, 18));
      if (n % 16 == 2) a = p - 255'd1;
      start_v = 3'b111;
      for (int k = 0; k <= 53; k++) begin
        @(posedge clk);
        #1;
        if (k == 0) start_v = 3'b000;
        if (k == 17) chk("rand lat17", 255'(done_v[1]), 255'd1);
        if (k == 19) chk("rand lat19", 255'(done_v[0]), 255'd1);
        if (k == 53) chk("rand lat53", 255'(done_v[2]), 255'd1);
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
